// File: rtl/ps2_apb_poller_if.sv
// APB bus between the PS/2 poller (master) and the PS/2 host block (slave).
interface ps2_apb_poller_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, perr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, perr
    );
endinterface

// File: rtl/ps2_apb_poller.sv
// PS/2 host poller: configures the host over APB, then reads scancode bytes,
// folds 0xF0/0xE0 prefixes into release/extended flags, hands complete keys
// downstream, and reads the status register whenever the FIFO is empty or
// a bus error occurs.
module ps2_apb_poller (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [15:0]              divider,
    input  logic [7:0]               poll_interval,
    ps2_apb_poller_if.master         apb,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic [7:0]               key_code,
    output logic                     key_release,
    output logic                     key_extended,
    output logic [4:0]               error_flags,
    output logic                     error_valid,
    output logic                     busy
);

    localparam logic [31:0] ADDR_CTRL = 32'd0;
    localparam logic [31:0] ADDR_DATA = 32'd1;
    localparam logic [7:0]  BYTE_BREAK = 8'hF0;
    localparam logic [7:0]  BYTE_EXT   = 8'hE0;

    typedef enum logic [3:0] {
        IDLE,
        CFG_SETUP,
        CFG_ACCESS,
        DATA_SETUP,
        DATA_ACCESS,
        HOLD,
        STAT_SETUP,
        STAT_ACCESS,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cfg_div;
    logic        release_pend;
    logic        ext_pend;
    logic        data_perr;
    logic [7:0]  wait_cnt;

    logic        rd_empty;
    logic [7:0]  rd_byte;
    logic        rd_prefix;
    logic [4:0]  stat_flags;
    logic        unused_prdata;

    assign rd_empty      = apb.prdata[31] | apb.perr;
    assign rd_byte       = apb.prdata[7:0];
    assign rd_prefix     = (rd_byte == BYTE_BREAK) || (rd_byte == BYTE_EXT);
    assign stat_flags    = {apb.perr | data_perr, apb.prdata[3:0]};
    assign unused_prdata = ^apb.prdata[30:8];
    assign busy          = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update together from pre-edge values, independent of block order.
            state <= state_nxt;
        end
    end

    // Next-state decode and APB request outputs, decoded from the state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt   = state;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;

        case (state)
            IDLE: begin
                if (enable) state_nxt = CFG_SETUP;
            end
            CFG_SETUP: begin
                apb.psel   = 1'b1;
                apb.pwrite = 1'b1;
                apb.paddr  = ADDR_CTRL;
                apb.pwdata = {cfg_div, 16'h0000};
                state_nxt  = CFG_ACCESS;
            end
            CFG_ACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = 1'b1;
                apb.pwrite  = 1'b1;
                apb.paddr   = ADDR_CTRL;
                apb.pwdata  = {cfg_div, 16'h0000};
                if (apb.pready) state_nxt = enable ? DATA_SETUP : IDLE;
            end
            DATA_SETUP: begin
                apb.psel  = 1'b1;
                apb.paddr = ADDR_DATA;
                state_nxt = DATA_ACCESS;
            end
            DATA_ACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = 1'b1;
                apb.paddr   = ADDR_DATA;
                if (apb.pready) begin
                    if (rd_empty)       state_nxt = enable ? STAT_SETUP : IDLE;
                    else if (rd_prefix) state_nxt = enable ? DATA_SETUP : IDLE;
                    else                state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (key_ready) state_nxt = enable ? DATA_SETUP : IDLE;
            end
            STAT_SETUP: begin
                apb.psel  = 1'b1;
                apb.paddr = ADDR_CTRL;
                state_nxt = STAT_ACCESS;
            end
            STAT_ACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = 1'b1;
                apb.paddr   = ADDR_CTRL;
                if (apb.pready) state_nxt = enable ? WAIT : IDLE;
            end
            WAIT: begin
                if (!enable)             state_nxt = IDLE;
                else if (wait_cnt == 0)  state_nxt = DATA_SETUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: divider capture, prefix tracking, key and error registers,
    // and the poll-interval counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_div      <= '0;
            release_pend <= 1'b0;
            ext_pend     <= 1'b0;
            data_perr    <= 1'b0;
            wait_cnt     <= '0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_release  <= 1'b0;
            key_extended <= 1'b0;
            error_flags  <= '0;
            error_valid  <= 1'b0;
        end else begin
            error_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) cfg_div <= divider;
                end
                DATA_ACCESS: begin
                    if (apb.pready) begin
                        data_perr <= apb.perr;
                        if (!rd_empty) begin
                            if (rd_byte == BYTE_BREAK) begin
                                release_pend <= 1'b1;
                            end else if (rd_byte == BYTE_EXT) begin
                                ext_pend <= 1'b1;
                            end else begin
                                key_valid    <= 1'b1;
                                key_code     <= rd_byte;
                                key_release  <= release_pend;
                                key_extended <= ext_pend;
                                release_pend <= 1'b0;
                                ext_pend     <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (key_ready) key_valid <= 1'b0;
                end
                STAT_ACCESS: begin
                    if (apb.pready) begin
                        error_flags <= stat_flags;
                        error_valid <= 1'b1;
                        wait_cnt    <= poll_interval;
                        if (|stat_flags) begin
                            release_pend <= 1'b0;
                            ext_pend     <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt != 0) wait_cnt <= wait_cnt - 8'd1;
                end
                default: ;
            endcase

            // A half-received prefix sequence never survives a stop.
            if (state_nxt == IDLE) begin
                release_pend <= 1'b0;
                ext_pend     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_apb_poller.md
PS2_APB_POLLER -- requirements
Module: ps2_apb_poller

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: enable  in  1  run request; poller configures, then polls while high.
REQ-004 SHALL have ports: divider  in  16  3us divider value written to PS/2 host at configuration.
REQ-005 SHALL have ports: poll_interval  in  8  idle cycles between polls after an empty FIFO.
REQ-006 SHALL have ports: apb_request__paddr  out  32, __psel  out  1, __penable  out  1, __pwrite  out  1, __pwdata  out  32  APB master request.
REQ-007 SHALL have ports: apb_response__prdata  in  32, __pready  in  1, __perr  in  1  APB response.
REQ-008 SHALL have ports: key_valid  out  1, key_ready  in  1, key_code  out  8, key_release  out  1, key_extended  out  1  decoded scancode stream.
REQ-009 SHALL have ports: error_flags  out  5  {bus_err, overflow, timeout, protocol_error, parity_error}; error_valid  out  1  one-cycle update strobe; busy  out  1  high when state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, CFG_SETUP, CFG_ACCESS, DATA_SETUP, DATA_ACCESS, HOLD, STAT_SETUP, STAT_ACCESS, WAIT.
REQ-011 SHALL drive each APB transfer as follows:
- SETUP phase: psel=1, penable=0, for one cycle.
- ACCESS phase: psel=1, penable=1, held until pready=1.
- All other states: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
REQ-012 SHALL, in IDLE with enable=1, go to CFG_SETUP; CFG transfer is a write, paddr=0, pwdata={divider,16'h0}. This write also flushes the target FIFO and clears its errors.
REQ-013 SHALL, on CFG_ACCESS completion, go to DATA_SETUP; DATA transfer is a read, paddr=1.
REQ-014 SHALL, on DATA_ACCESS completion, act on prdata[31] (empty) and perr:
- prdata[31]=1 or perr=1: go to STAT_SETUP.
- Otherwise decode byte b=prdata[7:0] per REQ-015.
REQ-015 Byte decode SHALL be:
- b=0xF0: set release_pend; go to DATA_SETUP.
- b=0xE0: set ext_pend; go to DATA_SETUP.
- Any other b: register key_code=b, key_release=release_pend, key_extended=ext_pend, key_valid=1; clear both pend flags; go to HOLD.
REQ-016 SHALL hold key_valid, key_code, key_release and key_extended stable in HOLD until key_ready=1. In that same cycle key_valid drops; next state is DATA_SETUP if enable=1, else IDLE.
REQ-017 SHALL perform STAT as a read, paddr=0. On completion:
- error_flags[3:0] <= prdata[3:0]; error_flags[4] <= perr of this transfer or of the preceding DATA transfer.
- error_valid=1 for exactly one cycle.
- Both pend flags cleared if any error_flags bit is set.
- Then go to WAIT.
REQ-018 WAIT SHALL load an 8-bit counter with poll_interval on entry, decrement each cycle, and exit to DATA_SETUP in the cycle the counter equals 0. poll_interval=0 gives exactly one WAIT cycle.
REQ-019 SHALL go to IDLE from WAIT immediately when enable=0. enable=0 during any APB phase SHALL NOT abort the transfer; the FSM completes it, then goes to IDLE instead of issuing another transfer. This does not apply to HOLD (REQ-016).
REQ-020 SHALL clear release_pend and ext_pend on entering IDLE. Re-asserting enable always repeats configuration.
REQ-021 SHALL honour pready=0 for any number of cycles, holding all request outputs constant.
REQ-022 Minimum poll rate: a non-empty byte read takes 2 cycles (setup+access) with pready=1. Back-to-back reads SHALL occur with no idle cycle between transfers.

Reset
REQ-023 SHALL, on reset_n low, asynchronously enter IDLE and set every output, the pend flags and the WAIT counter to 0.
REQ-024 Reset asserted mid-transfer or in HOLD SHALL drop psel and key_valid immediately; no partial state is retained.

Verification
REQ-025 Config: reset, divider=0x0123, enable=1 -> cycle 1 psel=1/penable=0/pwrite=1/paddr=0/pwdata=0x01230000; cycle 2 penable=1; cycle 3 DATA read paddr=1.
REQ-026 Make code: target returns 0x0000001C -> key_valid=1, key_code=0x1C, release=0, extended=0. With key_ready low for 5 cycles, outputs stay stable and no APB activity occurs.
REQ-027 Extended break: reads return 0xE0, 0xF0, 0x75 -> single key_valid with key_code=0x75, key_release=1, key_extended=1; the next key has both flags 0.
REQ-028 Empty and errors: data read returns 0x80000000, status returns 0x0000001A -> error_flags=5'b01010, error_valid one cycle, then WAIT of poll_interval+1 cycles, then DATA read.
REQ-029 Stalls and disable: pready held low 3 cycles in DATA_ACCESS -> request held constant. enable dropped during that stall -> transfer completes, then IDLE with busy=0. Separately, perr=1 on a read -> error_flags[4]=1.
